vlog_tap_arbiter: RTL

Collects pass/fail results from several independent checkers in a testbench and serialises them into a single, numbered TAP record stream for the TAP file writer. Requesters are served round-robin. Each accepted result gets the next testcase number. Pass/fail totals and a plan check are reported when the bench signals completion.

---
 rtl/vlog_tap_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vlog_tap_arbiter.sv
// Round-robin arbiter that serialises checker results into numbered TAP records.
// Tracks pass/fail totals and reports a plan check once finish is seen.
module vlog_tap_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int TC_W  = 16,
  parameter int PLAN  = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] ok_i,
  output logic [N_REQ-1:0] ack_o,
  output logic             rec_valid_o,
  input  logic             rec_ready_i,
  output logic [TC_W-1:0]  rec_num_o,
  output logic             rec_ok_o,
  output logic [ID_W-1:0]  rec_src_o,
  input  logic             finish_i,
  output logic [TC_W-1:0]  pass_cnt_o,
  output logic [TC_W-1:0]  fail_cnt_o,
  output logic             done_o,
  output logic             plan_ok_o
);

  localparam int NX = 2**ID_W;
  localparam logic [TC_W-1:0] CMAX  = '1;
  localparam logic [TC_W-1:0] CPLAN = TC_W'(PLAN);
  localparam logic [ID_W-1:0] LAST  = ID_W'(N_REQ-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [TC_W-1:0]  tc_q, tc_d;
  logic [TC_W-1:0]  pass_q, pass_d;
  logic [TC_W-1:0]  fail_q, fail_d;
  logic [TC_W-1:0]  num_q, num_d;
  logic             rok_q, rok_d;
  logic [ID_W-1:0]  src_q, src_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             fin_q, fin_d;
  logic             done_q, done_d;
  logic             plan_q, plan_d;

  logic [NX-1:0]    req_x, ok_x, ack_x;
  logic [ID_W:0]    cand;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_idx;
  logic [TC_W-1:0]  tc_inc, pass_inc, fail_inc;

  // Pad to a power of two so an ID_W-bit index always fits.
  assign req_x = NX'(req_i);
  assign ok_x  = NX'(ok_i);
  assign ack_x = NX'(1) << gnt_idx;

  assign tc_inc   = (tc_q == CMAX)   ? tc_q   : tc_q + TC_W'(1);
  assign pass_inc = (pass_q == CMAX) ? pass_q : pass_q + TC_W'(1);
  assign fail_inc = (fail_q == CMAX) ? fail_q : fail_q + TC_W'(1);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!gnt_vld && req_x[cand[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tc_d    = tc_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    num_d   = num_q;
    rok_d   = rok_q;
    src_d   = src_q;
    ack_d   = '0;
    fin_d   = fin_q | finish_i;
    done_d  = done_q;
    plan_d  = plan_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          ack_d   = ack_x[N_REQ-1:0];
          tc_d    = tc_inc;
          num_d   = tc_inc;
          rok_d   = ok_x[gnt_idx];
          src_d   = gnt_idx;
          ptr_d   = (gnt_idx == LAST) ? '0 : gnt_idx + ID_W'(1);
          state_d = OUT;
        end else if (fin_q || finish_i) begin
          done_d  = 1'b1;
          plan_d  = (PLAN == 0) || (tc_q == CPLAN);
          state_d = DONE;
        end
      end
      OUT: begin
        if (rec_ready_i) begin
          if (rok_q) pass_d = pass_inc;
          else       fail_d = fail_inc;
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tc_q    <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      num_q   <= '0;
      rok_q   <= 1'b0;
      src_q   <= '0;
      ack_q   <= '0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
      plan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tc_q    <= tc_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      num_q   <= num_d;
      rok_q   <= rok_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
      plan_q  <= plan_d;
    end
  end

  assign ack_o       = ack_q;
  assign rec_valid_o = (state_q == OUT);
  assign rec_num_o   = num_q;
  assign rec_ok_o    = rok_q;
  assign rec_src_o   = src_q;
  assign pass_cnt_o  = pass_q;
  assign fail_cnt_o  = fail_q;
  assign done_o      = done_q;
  assign plan_ok_o   = plan_q;

endmodule
